led_step_gen: RTL and testbench

LED_STEP_GEN -- requirements
Module: led_step_gen

---
 rtl/led_step_gen.sv | 118 +++++++++++
 tb/tb_led_step_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_step_gen.sv
// rtl/led_step_gen.sv - debounced speed/dir/pause buttons driving a periodic LED ripple step pulse
// Three button front ends feed one step-rate generator; all state resets asynchronously.

module led_step_debounce #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // The level flips on the last differing cycle; a rising flip is the press.
  always_comb begin
    accept  = (sync2_q != level_q) && (cnt_q == LAST);
    level_d = accept ? sync2_q : level_q;
    if ((sync2_q == level_q) || accept) cnt_d = '0;
    else                                cnt_d = cnt_q + CW'(1);
  end

  assign press_o = accept && sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module led_step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BASE_DIV        = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_speed,
  input  logic       btn_dir,
  input  logic       btn_pause,
  output logic       step,
  output logic       dir,
  output logic [1:0] speed_sel,
  output logic       paused
);
  localparam int unsigned W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  // One spare bit so BASE_DIV itself is representable before the shift.
  localparam logic [W:0] BASE = (W+1)'(BASE_DIV);

  logic ev_speed, ev_dir, ev_pause;

  led_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk(clk), .rst(rst), .raw_i(btn_speed), .press_o(ev_speed)
  );
  led_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk(clk), .rst(rst), .raw_i(btn_dir), .press_o(ev_dir)
  );
  led_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .rst(rst), .raw_i(btn_pause), .press_o(ev_pause)
  );

  logic [W-1:0] cnt_q, cnt_d;
  logic [1:0]   speed_q, speed_d;
  logic         dir_q, dir_d;
  logic         paused_q, paused_d;
  logic         step_q, step_d;

  function automatic logic [W:0] terminal(input logic [1:0] sel);
    return (BASE >> sel) - (W+1)'(1);
  endfunction

  // step_q is precomputed from next state so it is high exactly while cnt_q sits at terminal.
  always_comb begin
    speed_d  = ev_speed ? speed_q + 2'd1 : speed_q;
    dir_d    = dir_q ^ ev_dir;
    paused_d = paused_q ^ ev_pause;
    cnt_d    = cnt_q;
    if (!paused_q)
      cnt_d = ({1'b0, cnt_q} == terminal(speed_q)) ? '0 : cnt_q + W'(1);
    if (ev_speed)
      cnt_d = '0;
    step_d = !paused_d && ({1'b0, cnt_d} == terminal(speed_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      speed_q  <= 2'd0;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      step_q   <= step_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign speed_sel = speed_q;
  assign paused    = paused_q;
endmodule

// File: tb/tb_led_step_gen.sv
// tb/tb_led_step_gen.sv - scoreboard bench for led_step_gen
// Expected step cycles are queued as stimulus is planned; a monitor pops them as steps appear.
`timescale 1ns/1ps
module tb_led_step_gen;
  localparam int DEB  = 4;
  localparam int BASE = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_speed = 1'b0, btn_dir = 1'b0, btn_pause = 1'b0;
  logic       step, dir, paused;
  logic [1:0] speed_sel;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int exp_q[$];
  bit mon_en = 1'b0;

  led_step_gen #(.DEBOUNCE_CYCLES(DEB), .BASE_DIV(BASE)) dut (
    .clk(clk), .rst(rst), .btn_speed(btn_speed), .btn_dir(btn_dir), .btn_pause(btn_pause),
    .step(step), .dir(dir), .speed_sel(speed_sel), .paused(paused)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_total++;
        $display("FAIL step_missing: step=0 at cycle %0d, required 1 (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (step) begin
        n_total++;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          n_pass++;
          void'(exp_q.pop_front());
        end else begin
          $display("FAIL step_unexpected: step=1 at cycle %0d, next required step at %0d",
                   cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(output int e);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    e = cyc;
    mon_en = 1'b1;
  endtask

  task automatic push_sched(input int s, input int d, input int stop);
    for (int t = s + d - 1; t < stop; t += d) exp_q.push_back(t);
  endtask

  task automatic finish_sched(input int stop);
    until_cyc(stop - 1);
    mon_en = 1'b0;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL sched_drain: %0d steps never seen, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    int e;
    rst = 1'b1;
    tick(2);
    n_total++; if (step !== 1'b0) $display("FAIL rst_step: got %b want 0", step); else n_pass++;
    n_total++; if (dir !== 1'b0) $display("FAIL rst_dir: got %b want 0", dir); else n_pass++;
    n_total++; if (speed_sel !== 2'd0) $display("FAIL rst_speed: got %0d want 0", speed_sel); else n_pass++;
    n_total++; if (paused !== 1'b0) $display("FAIL rst_paused: got %b want 0", paused); else n_pass++;
    exp_q.delete();
    rst = 1'b0;
    e = cyc;
    mon_en = 1'b1;
    push_sched(e, BASE, e + 70);
    tick(5);
    n_total++; if (dir !== 1'b0) $display("FAIL idle_dir: got %b want 0", dir); else n_pass++;
    n_total++; if (speed_sel !== 2'd0) $display("FAIL idle_speed: got %0d want 0", speed_sel); else n_pass++;
    n_total++; if (paused !== 1'b0) $display("FAIL idle_paused: got %b want 0", paused); else n_pass++;
    finish_sched(e + 70);
  endtask

  task automatic test_speed();
    int e;
    int p[4];
    int s[4];
    do_reset(e);
    p[0] = e + 3; p[1] = p[0] + 20; p[2] = p[1] + 16; p[3] = p[2] + 16;
    for (int k = 0; k < 4; k++) s[k] = p[k] + DEB + 2;
    push_sched(e, BASE, s[0]);
    for (int k = 0; k < 4; k++)
      push_sched(s[k], BASE >> ((k + 1) % 4), (k < 3) ? s[k+1] : s[3] + 40);
    for (int k = 0; k < 4; k++) begin
      until_cyc(p[k]);
      btn_speed = 1'b1;
      until_cyc(s[k] - 1);
      n_total++;
      if (speed_sel !== 2'(k)) $display("FAIL speed_before_%0d: got %0d want %0d", k, speed_sel, k);
      else n_pass++;
      until_cyc(s[k]);
      n_total++;
      if (speed_sel !== 2'((k + 1) % 4)) $display("FAIL speed_after_%0d: got %0d want %0d", k, speed_sel, (k + 1) % 4);
      else n_pass++;
      until_cyc(p[k] + ((k == 0) ? 10 : 8));
      btn_speed = 1'b0;
    end
    finish_sched(s[3] + 40);
  endtask

  task automatic test_glitch();
    int e;
    do_reset(e);
    push_sched(e, BASE, e + 70);
    until_cyc(e + 2);
    btn_dir = 1'b1;
    tick(2);
    btn_dir = 1'b0;
    tick(6);
    n_total++; if (dir !== 1'b0) $display("FAIL glitch_pulse_dir: got %b want 0", dir); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      btn_dir = ~btn_dir;
      tick(3);
    end
    n_total++; if (dir !== 1'b0) $display("FAIL glitch_bounce_dir: got %b want 0", dir); else n_pass++;
    tick(10);
    n_total++; if (dir !== 1'b0) $display("FAIL glitch_settle_dir: got %b want 0", dir); else n_pass++;
    finish_sched(e + 70);
  endtask

  task automatic test_pause();
    int e;
    int r;
    do_reset(e);
    btn_pause = 1'b1;
    until_cyc(e + DEB + 1);
    n_total++; if (paused !== 1'b0) $display("FAIL pause_early: got %b want 0", paused); else n_pass++;
    until_cyc(e + DEB + 2);
    n_total++; if (paused !== 1'b1) $display("FAIL pause_set: got %b want 1", paused); else n_pass++;
    until_cyc(e + 8);
    btn_pause = 1'b0;
    r = e + 106;
    until_cyc(r - DEB - 2);
    btn_pause = 1'b1;
    for (int t = r + 9; t < r + 50; t += BASE) exp_q.push_back(t);
    until_cyc(r - 1);
    n_total++; if (paused !== 1'b1) $display("FAIL pause_held: got %b want 1", paused); else n_pass++;
    until_cyc(r);
    n_total++; if (paused !== 1'b0) $display("FAIL pause_resume: got %b want 0", paused); else n_pass++;
    until_cyc(r + 8);
    btn_pause = 1'b0;
    finish_sched(r + 50);
  endtask

  task automatic test_simul();
    int e;
    do_reset(e);
    until_cyc(e + 2);
    btn_dir = 1'b1;
    btn_pause = 1'b1;
    until_cyc(e + 7);
    n_total++; if ({dir, paused} !== 2'b00) $display("FAIL simul_before: got %b want 00", {dir, paused}); else n_pass++;
    until_cyc(e + 8);
    n_total++; if ({dir, paused} !== 2'b11) $display("FAIL simul_after: got %b want 11", {dir, paused}); else n_pass++;
    until_cyc(e + 12);
    btn_dir = 1'b0;
    btn_pause = 1'b0;
    finish_sched(e + 40);
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset(e);
    mon_en = 1'b0;
    btn_speed = 1'b1; btn_dir = 1'b1; btn_pause = 1'b1;
    tick(8);
    btn_speed = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;
    tick(8);
    btn_speed = 1'b1;
    tick(8);
    btn_speed = 1'b0;
    tick(8);
    n_total++;
    if ({speed_sel, dir, paused} !== 4'b1011)
      $display("FAIL mid_setup: got speed=%0d dir=%b paused=%b want speed=2 dir=1 paused=1", speed_sel, dir, paused);
    else n_pass++;
    btn_speed = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    n_total++; if (step !== 1'b0) $display("FAIL mid_step: got %b want 0", step); else n_pass++;
    n_total++; if (dir !== 1'b0) $display("FAIL mid_dir: got %b want 0", dir); else n_pass++;
    n_total++; if (speed_sel !== 2'd0) $display("FAIL mid_speed: got %0d want 0", speed_sel); else n_pass++;
    n_total++; if (paused !== 1'b0) $display("FAIL mid_paused: got %b want 0", paused); else n_pass++;
    tick(2);
    rst = 1'b0;
    e = cyc;
    until_cyc(e + DEB + 1);
    n_total++; if (speed_sel !== 2'd0) $display("FAIL held_early: got %0d want 0", speed_sel); else n_pass++;
    until_cyc(e + DEB + 2);
    n_total++; if (speed_sel !== 2'd1) $display("FAIL held_press: got %0d want 1", speed_sel); else n_pass++;
    btn_speed = 1'b0;
    tick(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_speed();
    test_glitch();
    test_pause();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
